// File: rtl/wb_arbiter.sv
// Writeback arbiter: four one-entry result slots feed one registered register-file write port.
// Latency is one cycle from capture to wb_en; slots refill on the edge they drain; WB_ARB_RR_EN selects round-robin.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [RD_W-1:0]      alu_rd,
  input  logic [RD_W-1:0]      ld_rd,
  input  logic [RD_W-1:0]      mul_rd,
  input  logic [RD_W-1:0]      div_rd,
  input  logic [DATA_W-1:0]    alu_res,
  input  logic [DATA_W-1:0]    ld_res,
  input  logic [DATA_W-1:0]    mul_res,
  input  logic [DATA_W-1:0]    div_res,
  output logic                 wb_en,
  output logic [RD_W-1:0]      wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  output logic [3:0]           slot_busy,
  output logic [2**RD_W-1:0]   rd_pending
);

  logic [3:0]        r_busy;
  logic [RD_W-1:0]   r_rd  [4];
  logic [DATA_W-1:0] r_res [4];
  logic              r_wb_en;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic [RD_W-1:0]   w_in_rd  [4];
  logic [DATA_W-1:0] w_in_res [4];
  logic [3:0]        w_grant;
  logic [3:0]        w_accept;
  logic [1:0]        w_gidx;
  logic              w_found;

  assign w_in_rd[3]  = alu_rd;
  assign w_in_rd[2]  = ld_rd;
  assign w_in_rd[1]  = mul_rd;
  assign w_in_rd[0]  = div_rd;
  assign w_in_res[3] = alu_res;
  assign w_in_res[2] = ld_res;
  assign w_in_res[1] = mul_res;
  assign w_in_res[0] = div_res;

`ifdef WB_ARB_RR_EN
  // Pointer walks downward through bit indices: ALU(3) -> LD(2) -> MUL(1) -> DIV(0) -> ALU.
  logic [1:0] r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_gidx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && r_busy[r_ptr - 2'(k)]) begin
        w_found = 1'b1;
        w_gidx  = r_ptr - 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd3;
    end else if (!flush && w_found) begin
      r_ptr <= w_gidx - 2'd1;
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_gidx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!w_found && r_busy[k]) begin
        w_found = 1'b1;
        w_gidx  = 2'(k);
      end
    end
  end
`endif

  always_comb begin
    w_grant = 4'd0;
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  assign req_ready = {4{~flush}} & (~r_busy | w_grant);
  assign w_accept  = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 4'd0;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      for (int i = 0; i < 4; i++) begin
        r_rd[i]  <= '0;
        r_res[i] <= '0;
      end
    end else if (flush) begin
      r_busy  <= 4'd0;
      r_wb_en <= 1'b0;
    end else begin
      r_wb_en <= w_found;
      if (w_found) begin
        r_wb_rd   <= r_rd[w_gidx];
        r_wb_data <= r_res[w_gidx];
      end
      // A refill on the draining edge takes precedence over the clear.
      for (int i = 0; i < 4; i++) begin
        if (w_accept[i]) begin
          r_busy[i] <= 1'b1;
          r_rd[i]   <= w_in_rd[i];
          r_res[i]  <= w_in_res[i];
        end else if (w_grant[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_busy[i]) rd_pending[r_rd[i]] = 1'b1;
    end
  end

  assign slot_busy = r_busy;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; expected writebacks are queued at offer time and popped on wb_en.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  alu_rd, ld_rd, mul_rd, div_rd;
  logic [31:0] alu_res, ld_res, mul_res, div_res;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  slot_busy;
  logic [15:0] rd_pending;

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] sb [$];

  wb_arbiter #(.DATA_W(32), .RD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .alu_rd(alu_rd), .ld_rd(ld_rd), .mul_rd(mul_rd), .div_rd(div_rd),
    .alu_res(alu_res), .ld_res(ld_res), .mul_res(mul_res), .div_res(div_res),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .slot_busy(slot_busy), .rd_pending(rd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare any writeback against the head of the scoreboard.
  task automatic tick();
    logic [35:0] e;
    @(posedge clk);
    #1;
    if (wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_spurious", {63'd0, wb_en}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", {60'd0, wb_rd}, {60'd0, e[35:32]});
        chk("wb_data", {32'd0, wb_data}, {32'd0, e[31:0]});
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2;
    chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
    chk("rst_wb_rd", {60'd0, wb_rd}, 64'd0);
    chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
    chk("rst_busy", {60'd0, slot_busy}, 64'd0);
    chk("rst_pending", {48'd0, rd_pending}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'hF);
    #1 rst_n = 1'b1;
  endtask

`ifdef WB_ARB_RR_EN
  logic [3:0] col_busy  [4] = '{4'b1111, 4'b1011, 4'b1001, 4'b1000};
  logic [3:0] col_ready [4] = '{4'b0100, 4'b0110, 4'b0111, 4'b1111};
  logic [3:0] col_order [4] = '{4'd2, 4'd3, 4'd4, 4'd1};
`else
  logic [3:0] col_busy  [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] col_ready [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
  logic [3:0] col_order [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
`endif

  initial begin
    int k;
    logic r;
    rst_n = 1'b1; flush = 1'b0; req_valid = 4'd0;
    alu_rd = '0; ld_rd = '0; mul_rd = '0; div_rd = '0;
    alu_res = '0; ld_res = '0; mul_res = '0; div_res = '0;
    #1;
    do_reset();

    // Single ALU result
    @(posedge clk); #1;
    req_valid = 4'b1000; alu_rd = 4'd5; alu_res = 32'hDEADBEEF;
    sb.push_back({4'd5, 32'hDEADBEEF});
    tick();
    req_valid = 4'd0;
    chk("single_busy", {60'd0, slot_busy}, 64'b1000);
    chk("single_pending", {48'd0, rd_pending}, 64'h0020);
    chk("single_wb_early", {63'd0, wb_en}, 64'd0);
    tick();
    chk("single_wb_en", {63'd0, wb_en}, 64'd1);
    chk("single_pending_clr", {48'd0, rd_pending}, 64'd0);
    tick();
    chk("single_wb_once", {63'd0, wb_en}, 64'd0);
    chk("single_drain", sb.size(), 64'd0);

    // Four-way collision
    req_valid = 4'b1111;
    alu_rd = 4'd1; ld_rd = 4'd2; mul_rd = 4'd3; div_rd = 4'd4;
    alu_res = 32'h101; ld_res = 32'h102; mul_res = 32'h103; div_res = 32'h104;
    for (int i = 0; i < 4; i++) sb.push_back({col_order[i], 32'h100 + {28'd0, col_order[i]}});
    tick();
    req_valid = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("col_busy", {60'd0, slot_busy}, {60'd0, col_busy[i]});
      chk("col_ready", {60'd0, req_ready}, {60'd0, col_ready[i]});
      tick();
      chk("col_wb_en", {63'd0, wb_en}, 64'd1);
    end
    tick();
    chk("col_drain", sb.size(), 64'd0);
    chk("col_idle", {60'd0, slot_busy}, 64'd0);

    // ALU streaming against one held DIV result
    do_reset();
    @(posedge clk); #1;
    k = 0;
    req_valid = 4'b1001; alu_rd = 4'd7; alu_res = 32'h700;
    div_rd = 4'd9; div_res = 32'h900;
    sb.push_back({4'd7, 32'h700});
`ifdef WB_ARB_RR_EN
    sb.push_back({4'd9, 32'h900});
`endif
    tick();
    k = 1; alu_res = 32'h701; req_valid = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      r = req_ready[3];
`ifndef WB_ARB_RR_EN
      chk("stream_div_ready", {63'd0, req_ready[0]}, 64'd0);
      chk("stream_div_busy", {63'd0, slot_busy[0]}, 64'd1);
`endif
      if (r) sb.push_back({4'd7, 32'h700 + 32'(k)});
      tick();
      if (r) begin
        k++;
        alu_res = 32'h700 + 32'(k);
      end
    end
`ifdef WB_ARB_RR_EN
    chk("stream_div_done", {63'd0, slot_busy[0]}, 64'd0);
`endif
    req_valid = 4'd0;
`ifndef WB_ARB_RR_EN
    sb.push_back({4'd9, 32'h900});
`endif
    tick(); tick(); tick();
    chk("stream_drain", sb.size(), 64'd0);

    // MUL alone streams eight results
    mul_rd = 4'd3;
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'b0010; mul_res = 32'(i);
      sb.push_back({4'd3, 32'(i)});
      chk("mul_ready", {63'd0, req_ready[1]}, 64'd1);
      tick();
      if (i > 0) chk("mul_wb_en", {63'd0, wb_en}, 64'd1);
    end
    req_valid = 4'd0;
    tick();
    chk("mul_wb_last", {63'd0, wb_en}, 64'd1);
    tick();
    chk("mul_wb_off", {63'd0, wb_en}, 64'd0);
    chk("mul_drain", sb.size(), 64'd0);

    // Flush with three slots busy and a fresh LD offer
    req_valid = 4'b1011;
    alu_rd = 4'd10; mul_rd = 4'd12; div_rd = 4'd13;
    tick();
    chk("flush_pre_busy", {60'd0, slot_busy}, 64'b1011);
    flush = 1'b1; req_valid = 4'b0100; ld_rd = 4'd11; ld_res = 32'hBAD;
    #1;
    chk("flush_ready", {60'd0, req_ready}, 64'd0);
    tick();
    flush = 1'b0; req_valid = 4'd0;
    chk("flush_busy", {60'd0, slot_busy}, 64'd0);
    chk("flush_pending", {48'd0, rd_pending}, 64'd0);
    chk("flush_wb_en", {63'd0, wb_en}, 64'd0);
    tick(); tick();
    chk("flush_quiet", {60'd0, slot_busy}, 64'd0);

    // Asynchronous reset with two results held
    req_valid = 4'b1100; alu_rd = 4'd1; ld_rd = 4'd2;
    tick();
    req_valid = 4'd0;
    chk("arst_pre_busy", {60'd0, slot_busy}, 64'b1100);
    do_reset();
    tick(); tick(); tick();
    chk("arst_busy_after", {60'd0, slot_busy}, 64'd0);
    chk("arst_drain", sb.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
